// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
//   Per-voice ADSR envelope generator followed by a VCA stage. The envelope
//   walks IDLE -> ATTACK -> DECAY -> SUSTAIN -> RELEASE -> IDLE, one level
//   step every 2**rate samples. The oscillator sample is scaled about
//   mid-scale by the current 8-bit level and registered.
//
// Ports
//   sample_clock  : sample-rate clock, all logic on its rising edge
//   reset         : asynchronous, active-high reset
//   gate          : note on (1) / off (0)
//   attack        : attack rate r, one level step every 2**r samples
//   decay         : decay rate, same encoding
//   sustain       : sustain level S4, effective level {S4,S4}
//   release_rate  : release rate, same encoding
//   in            : oscillator sample, unsigned, centred on 2**(BITDEPTH-1)
//   out           : enveloped sample, unsigned, same centre
//   level         : current envelope level
//   state         : IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy          : high whenever state is not IDLE
// ---------------------------------------------------------------------------
module adsr_envelope #(
    parameter int BITDEPTH      = 12,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                sample_clock,
    input  logic                reset,
    input  logic                gate,
    input  logic [3:0]          attack,
    input  logic [3:0]          decay,
    input  logic [3:0]          sustain,
    input  logic [3:0]          release_rate,
    input  logic [BITDEPTH-1:0] in,
    output logic [BITDEPTH-1:0] out,
    output logic [7:0]          level,
    output logic [2:0]          state,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [BITDEPTH-1:0]      MID    = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic [PRESCALE_BITS-1:0] P_ZERO = {PRESCALE_BITS{1'b0}};
    localparam logic [PRESCALE_BITS-1:0] P_ONE  = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

    state_t                   state_r;
    logic [7:0]               level_r;
    logic [PRESCALE_BITS-1:0] prescaler_r;
    logic                     gate_d_r;
    logic                     busy_r;
    logic [BITDEPTH-1:0]      out_r;

    logic [3:0]               rate_s;
    logic [PRESCALE_BITS-1:0] limit_s;
    logic                     step_s;
    logic                     rise_s;
    logic                     fall_s;
    logic [7:0]               sus_level_s;

    assign rise_s      = gate & ~gate_d_r;
    assign fall_s      = ~gate & gate_d_r;
    assign sus_level_s = {sustain, sustain};

    // Select the rate that paces the current phase.
    always_comb begin
        rate_s = 4'd0;
        case (state_r)
            ST_ATTACK:  rate_s = attack;
            ST_DECAY:   rate_s = decay;
            ST_RELEASE: rate_s = release_rate;
            default:    rate_s = 4'd0;
        endcase
    end

    // A step fires when the prescaler has counted 2**rate samples.
    assign limit_s = (P_ONE << rate_s) - P_ONE;
    assign step_s  = (prescaler_r == limit_s);

    // Envelope state machine: state, level, prescaler, gate history, busy.
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            level_r     <= 8'd0;
            prescaler_r <= P_ZERO;
            gate_d_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            gate_d_r <= gate;
            if (rise_s) begin
                // Retrigger keeps the current level so the attack is click-free.
                state_r     <= ST_ATTACK;
                prescaler_r <= P_ZERO;
                busy_r      <= 1'b1;
            end else if (fall_s && (state_r == ST_ATTACK || state_r == ST_DECAY ||
                                    state_r == ST_SUSTAIN)) begin
                state_r     <= ST_RELEASE;
                prescaler_r <= P_ZERO;
                busy_r      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        level_r     <= 8'd0;
                        prescaler_r <= P_ZERO;
                        busy_r      <= 1'b0;
                    end
                    ST_ATTACK: begin
                        if (level_r == 8'hFF) begin
                            state_r     <= ST_DECAY;
                            prescaler_r <= P_ZERO;
                        end else if (step_s) begin
                            level_r     <= level_r + 8'd1;
                            prescaler_r <= P_ZERO;
                            if (level_r == 8'hFE) begin
                                state_r <= ST_DECAY;
                            end else begin
                                state_r <= ST_ATTACK;
                            end
                        end else begin
                            prescaler_r <= prescaler_r + P_ONE;
                        end
                    end
                    ST_DECAY: begin
                        if (level_r <= sus_level_s) begin
                            state_r     <= ST_SUSTAIN;
                            prescaler_r <= P_ZERO;
                        end else if (step_s) begin
                            level_r     <= level_r - 8'd1;
                            prescaler_r <= P_ZERO;
                            if ((level_r - 8'd1) == sus_level_s) begin
                                state_r <= ST_SUSTAIN;
                            end else begin
                                state_r <= ST_DECAY;
                            end
                        end else begin
                            prescaler_r <= prescaler_r + P_ONE;
                        end
                    end
                    ST_SUSTAIN: begin
                        // Level is frozen; a new sustain value only matters in DECAY.
                        prescaler_r <= P_ZERO;
                    end
                    ST_RELEASE: begin
                        if (level_r == 8'd0) begin
                            state_r     <= ST_IDLE;
                            prescaler_r <= P_ZERO;
                            busy_r      <= 1'b0;
                        end else if (step_s) begin
                            level_r     <= level_r - 8'd1;
                            prescaler_r <= P_ZERO;
                            if (level_r == 8'd1) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= ST_RELEASE;
                            end
                        end else begin
                            prescaler_r <= prescaler_r + P_ONE;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        level_r     <= 8'd0;
                        prescaler_r <= P_ZERO;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // VCA: signed offset from mid-scale times the unsigned level, floored /256.
    logic signed [BITDEPTH:0]   d_s;
    logic signed [BITDEPTH+9:0] p_s;
    logic [BITDEPTH-1:0]        out_nxt_s;
    logic                       unused_s;

    assign d_s = $signed({1'b0, in}) - $signed({1'b0, MID});
    assign p_s = $signed({{9{d_s[BITDEPTH]}}, d_s}) *
                 $signed({{(BITDEPTH+2){1'b0}}, level_r});
    // Bits [BITDEPTH+7:8] are the low bits of p >>> 8; the sum wraps back into range.
    assign out_nxt_s = MID + p_s[BITDEPTH+7:8];
    assign unused_s  = ^{p_s[BITDEPTH+9:BITDEPTH+8], p_s[7:0]};

    // Output register, one sample of latency from in/level.
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            out_r <= MID;
        end else begin
            out_r <= out_nxt_s;
        end
    end

    assign out   = out_r;
    assign level = level_r;
    assign state = state_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// ---------------------------------------------------------------------------
// tb_adsr_envelope
//   Directed and randomized stimulus for adsr_envelope, checked every cycle
//   against a behavioural envelope/VCA model, plus constant checks at the
//   key points of the envelope (full level, sustain, release end, rounding).
// ---------------------------------------------------------------------------
module tb_adsr_envelope;

    localparam int BD = 12;

    logic          sample_clock = 1'b0;
    logic          reset;
    logic          gate;
    logic [3:0]    attack, decay, sustain, release_rate;
    logic [BD-1:0] smp_in;
    logic [BD-1:0] out_w;
    logic [7:0]    level_w;
    logic [2:0]    state_w;
    logic          busy_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: phase number, level, samples since last step.
    int m_phase, m_level, m_elapsed, m_gate_prev, m_out;

    adsr_envelope #(.BITDEPTH(BD), .PRESCALE_BITS(16)) dut (
        .sample_clock (sample_clock),
        .reset        (reset),
        .gate         (gate),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .in           (smp_in),
        .out          (out_w),
        .level        (level_w),
        .state        (state_w),
        .busy         (busy_w)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_level     = 0;
        m_elapsed   = 0;
        m_gate_prev = 0;
        m_out       = 2048;
    endtask

    // Has this phase's interval of 2**rate samples elapsed on this edge?
    function automatic bit interval_done(input int rate);
        m_elapsed++;
        if (m_elapsed == (1 << rate)) begin
            m_elapsed = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model by one sample using the inputs present before the edge.
    task automatic model_edge();
        int  p, s, nxt;
        bit  rise, fall;
        p    = (int'(smp_in) - 2048) * m_level;
        s    = int'(sustain) * 17;
        rise = gate && !m_gate_prev;
        fall = !gate && m_gate_prev;
        nxt  = m_phase;
        if (rise) begin
            nxt = 1;
        end else if (fall && m_phase >= 1 && m_phase <= 3) begin
            nxt = 4;
        end else begin
            case (m_phase)
                1: if (m_level == 255) nxt = 2;
                   else if (interval_done(int'(attack))) begin
                       m_level++;
                       if (m_level == 255) nxt = 2;
                   end
                2: if (m_level <= s) nxt = 3;
                   else if (interval_done(int'(decay))) begin
                       m_level--;
                       if (m_level == s) nxt = 3;
                   end
                4: if (m_level == 0) nxt = 0;
                   else if (interval_done(int'(release_rate))) begin
                       m_level--;
                       if (m_level == 0) nxt = 0;
                   end
                default: if (m_phase == 0) m_level = 0;
            endcase
        end
        if (rise || nxt != m_phase) m_elapsed = 0;
        m_phase     = nxt;
        m_gate_prev = gate ? 1 : 0;
        m_out       = 2048 + (p >>> 8);
    endtask

    task automatic check_all();
        check("out",   32'(out_w),   32'(m_out));
        check("level", 32'(level_w), 32'(m_level));
        check("state", 32'(state_w), 32'(m_phase));
        check("busy",  32'(busy_w),  (m_phase != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge sample_clock);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; gate = 1'b0; smp_in = 12'd2048;
        attack = 4'd0; decay = 4'd0; sustain = 4'd8; release_rate = 4'd0;
        model_reset();
        #3;
        check("reset_out",   32'(out_w),   32'd2048);
        check("reset_level", 32'(level_w), 32'd0);
        check("reset_state", 32'(state_w), 32'd0);
        check("reset_busy",  32'(busy_w),  32'd0);
        @(posedge sample_clock); #1;
        check_all();
        reset = 1'b0;

        // Full attack then decay to sustain 0x88.
        smp_in = 12'd4095; gate = 1'b1;
        cycle();
        check("atk_enter", 32'(state_w), 32'd1);
        run(255);
        check("atk_full_level", 32'(level_w), 32'd255);
        check("atk_full_state", 32'(state_w), 32'd2);
        run(119);
        check("sus_level", 32'(level_w), 32'h88);
        check("sus_state", 32'(state_w), 32'd3);
        cycle();
        check("sus_out", 32'(out_w), 32'd3135);

        // Release from 0x88 at rate 0.
        gate = 1'b0;
        cycle();
        check("rel_enter", 32'(state_w), 32'd4);
        run(136);
        check("rel_end_level", 32'(level_w), 32'd0);
        check("rel_end_state", 32'(state_w), 32'd0);
        check("rel_end_busy",  32'(busy_w),  32'd0);
        smp_in = 12'($urandom_range(0, 4095));
        cycle();
        check("idle_out", 32'(out_w), 32'd2048);

        // Attack rate 2: one step every 4 samples.
        attack = 4'd2; smp_in = 12'd4095; gate = 1'b1;
        cycle();
        run(3);
        check("atk2_hold", 32'(level_w), 32'd0);
        cycle();
        check("atk2_first", 32'(level_w), 32'd1);
        run(3);
        check("atk2_hold2", 32'(level_w), 32'd1);
        cycle();
        check("atk2_second", 32'(level_w), 32'd2);
        run(248);
        check("atk2_level40", 32'(level_w), 32'h40);

        // Asynchronous reset between edges, mid-attack.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset_out",   32'(out_w),   32'd2048);
        check("areset_level", 32'(level_w), 32'd0);
        check("areset_state", 32'(state_w), 32'd0);
        check("areset_busy",  32'(busy_w),  32'd0);
        #1;
        reset = 1'b0;

        // Retrigger from RELEASE at 0x30.
        attack = 4'd0;
        cycle();
        run(48);
        check("retrig_pre", 32'(level_w), 32'h30);
        release_rate = 4'd3; gate = 1'b0;
        cycle();
        check("retrig_rel", 32'(state_w), 32'd4);
        run(2);
        gate = 1'b1;
        cycle();
        check("retrig_state", 32'(state_w), 32'd1);
        check("retrig_level", 32'(level_w), 32'h30);
        cycle();
        check("retrig_next", 32'(level_w), 32'h31);
        run(205);
        check("pre_full", 32'(level_w), 32'd254);
        gate = 1'b0;
        cycle();
        check("fall_beats_full_state", 32'(state_w), 32'd4);
        check("fall_beats_full_level", 32'(level_w), 32'd254);

        // Negative-swing rounding.
        release_rate = 4'd0;
        run(254);
        check("idle_again", 32'(state_w), 32'd0);
        gate = 1'b1;
        cycle();
        run(128);
        attack = 4'd15; smp_in = 12'd0;
        cycle();
        check("neg_round_128", 32'(out_w), 32'd1024);
        gate = 1'b0;
        cycle();
        run(128);
        attack = 4'd0; gate = 1'b1;
        cycle();
        cycle();
        attack = 4'd15; smp_in = 12'd1;
        cycle();
        check("neg_round_1", 32'(out_w), 32'd2040);
        gate = 1'b0;
        run(4);

        // Randomized section.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) gate = ~gate;
            if ($urandom_range(0, 149) == 0) begin
                attack       = 4'($urandom_range(0, 2));
                decay        = 4'($urandom_range(0, 2));
                release_rate = 4'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 99) == 0) sustain = 4'($urandom_range(0, 15));
            smp_in = 12'($urandom_range(0, 4095));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
